// File: rtl/audio_pkg.sv
// Shared types for the WM8731 audio link.
// Receiver state, channel tag and default word width.
package audio_pkg;

  localparam int I2S_WIDTH = 16;

  typedef enum logic [1:0] {
    S_SYNC,
    S_SHIFT,
    S_HOLD
  } rx_state_t;

  typedef enum logic {
    CH_L,
    CH_R
  } chan_t;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for one asynchronous codec pin.
// Clears to 0 on synchronous reset.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (reset) ff <= '0;
    else       ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/i2s_adc_receiver.sv
// I2S ADC receiver: oversampled codec pins to parallel stereo
// samples in the system clock domain.
module i2s_adc_receiver
  import audio_pkg::*;
#(
  parameter int WIDTH       = I2S_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             AUD_BCLK,
  input  logic             AUD_ADCLRCK,
  input  logic             AUD_ADCDAT,
  output logic [WIDTH-1:0] LDATA,
  output logic [WIDTH-1:0] RDATA,
  output logic             sample_valid,
  output logic             frame_error
);

  localparam int CW = $clog2(WIDTH + 1);

  logic bclk_s, lrck_s, dat_s;
  logic bclk_prev, lrck_prev;
  logic bclk_rise, lrck_edge;

  rx_state_t      state, state_nx;
  chan_t          chan, chan_nx;
  logic [CW-1:0]  bit_cnt, cnt_nx;
  logic [WIDTH-1:0] shift_q, shift_nx;
  logic [WIDTH-1:0] left_hold, hold_nx;
  logic           left_ok, left_ok_nx;
  logic [WIDTH-1:0] ldata_nx, rdata_nx;
  logic           valid_nx, err_nx;
  logic [WIDTH-1:0] word;
  logic [CW-1:0]  cnt_inc;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_bclk (
    .clk(Clk), .reset(Reset), .d(AUD_BCLK), .q(bclk_s)
  );

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_lrck (
    .clk(Clk), .reset(Reset), .d(AUD_ADCLRCK), .q(lrck_s)
  );

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_dat (
    .clk(Clk), .reset(Reset), .d(AUD_ADCDAT), .q(dat_s)
  );

  assign bclk_rise = bclk_s & ~bclk_prev;
  assign lrck_edge = bclk_rise & (lrck_s != lrck_prev);
  assign word      = {shift_q[WIDTH-2:0], dat_s};
  assign cnt_inc   = (bit_cnt == CW'(WIDTH)) ? bit_cnt
                                             : bit_cnt + 1'b1;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      bclk_prev <= 1'b0;
      lrck_prev <= 1'b0;
    end else begin
      bclk_prev <= bclk_s;
      if (bclk_rise) lrck_prev <= lrck_s;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state        <= S_SYNC;
      chan         <= CH_L;
      bit_cnt      <= '0;
      shift_q      <= '0;
      left_hold    <= '0;
      left_ok      <= 1'b0;
      LDATA        <= '0;
      RDATA        <= '0;
      sample_valid <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      state        <= state_nx;
      chan         <= chan_nx;
      bit_cnt      <= cnt_nx;
      shift_q      <= shift_nx;
      left_hold    <= hold_nx;
      left_ok      <= left_ok_nx;
      LDATA        <= ldata_nx;
      RDATA        <= rdata_nx;
      sample_valid <= valid_nx;
      frame_error  <= err_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    chan_nx    = chan;
    cnt_nx     = bit_cnt;
    shift_nx   = shift_q;
    hold_nx    = left_hold;
    left_ok_nx = left_ok;
    ldata_nx   = LDATA;
    rdata_nx   = RDATA;
    valid_nx   = 1'b0;
    err_nx     = 1'b0;
    unique case (state)
      S_SYNC: begin
        if (lrck_edge && !lrck_s) begin
          state_nx   = S_SHIFT;
          chan_nx    = CH_L;
          cnt_nx     = '0;
          shift_nx   = '0;
          left_ok_nx = 1'b0;
        end
      end
      S_SHIFT: begin
        if (lrck_edge) begin
          // Channel ended early: drop the whole frame in progress.
          err_nx     = 1'b1;
          left_ok_nx = 1'b0;
          hold_nx    = '0;
          shift_nx   = '0;
          cnt_nx     = '0;
          chan_nx    = CH_L;
          state_nx   = lrck_s ? S_SYNC : S_SHIFT;
        end else if (bclk_rise) begin
          shift_nx = word;
          cnt_nx   = cnt_inc;
          if (bit_cnt == CW'(WIDTH - 1)) begin
            state_nx = S_HOLD;
            if (chan == CH_L) begin
              hold_nx    = word;
              left_ok_nx = 1'b1;
            end else begin
              if (left_ok) begin
                ldata_nx = left_hold;
                rdata_nx = word;
                valid_nx = 1'b1;
              end
              left_ok_nx = 1'b0;
            end
          end
        end
      end
      S_HOLD: begin
        if (lrck_edge) begin
          state_nx = S_SHIFT;
          chan_nx  = lrck_s ? CH_R : CH_L;
          cnt_nx   = '0;
          shift_nx = '0;
        end
      end
      default: state_nx = S_SYNC;
    endcase
  end

endmodule

// File: tb/tb_i2s_adc_receiver.sv
// Randomized bench for i2s_adc_receiver with a frame-level
// reference model and a per-cycle output compare process.
module tb_i2s_adc_receiver;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        AUD_BCLK;
  logic        AUD_ADCLRCK;
  logic        AUD_ADCDAT;
  logic [15:0] LDATA;
  logic [15:0] RDATA;
  logic        sample_valid;
  logic        frame_error;

  i2s_adc_receiver #(.WIDTH(16), .SYNC_STAGES(2)) dut (
    .Clk(Clk),
    .Reset(Reset),
    .AUD_BCLK(AUD_BCLK),
    .AUD_ADCLRCK(AUD_ADCLRCK),
    .AUD_ADCDAT(AUD_ADCDAT),
    .LDATA(LDATA),
    .RDATA(RDATA),
    .sample_valid(sample_valid),
    .frame_error(frame_error)
  );

  always #10 Clk = ~Clk;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s actual=%h required=%h", name, act, req);
  endtask

  // Frame-level reference model
  logic [31:0] exp_q[$];
  int          exp_err   = 0;
  int          exp_valid = 0;
  bit          m_prev_lr = 1'b0;
  bit          m_track   = 1'b0;
  bit          m_short   = 1'b0;
  bit          m_left_ok = 1'b0;
  logic [15:0] m_cur_word = '0;
  logic [15:0] m_left_word = '0;
  logic [15:0] m_l = '0;
  logic [15:0] m_r = '0;

  int n_valid = 0;
  int n_err   = 0;
  int cyc     = 0;
  int pulse_cyc[$];

  always @(negedge Clk) begin
    cyc++;
    if (Reset) begin
      m_l = '0;
      m_r = '0;
    end else begin
      if (sample_valid) begin
        n_valid++;
        pulse_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 32'(sample_valid), 32'd0);
        end else begin
          {m_l, m_r} = exp_q.pop_front();
        end
      end
      if (frame_error) n_err++;
      chk("valid_and_error", 32'(sample_valid & frame_error), 32'd0);
      chk("ldata", 32'(LDATA), 32'(m_l));
      chk("rdata", 32'(RDATA), 32'(m_r));
    end
  end

  // A channel of n BCLK rises; the first rise is the delay slot.
  function automatic void model_chan(input bit lr,
                                     input logic [15:0] w,
                                     input int n);
    bit short_now;
    short_now = (n - 1) < 16;
    if (lr != m_prev_lr) begin
      if (!lr) begin
        if (m_track && m_short) exp_err++;
        m_track   = 1'b1;
        m_left_ok = 1'b0;
      end else begin
        if (m_track && m_short) begin
          exp_err++;
          m_track   = 1'b0;
          m_left_ok = 1'b0;
        end else if (m_track) begin
          m_left_ok   = 1'b1;
          m_left_word = m_cur_word;
        end else begin
          m_left_ok = 1'b0;
        end
      end
    end
    m_prev_lr  = lr;
    m_short    = short_now;
    m_cur_word = w;
    if (m_track && lr && !short_now && m_left_ok) begin
      exp_q.push_back({m_left_word, w});
      exp_valid++;
    end
  endfunction

  task automatic send_chan(input bit lr, input logic [15:0] w,
                           input int n, input logic [15:0] fill);
    logic b;
    model_chan(lr, w, n);
    for (int i = 0; i < n; i++) begin
      if (i == 0)       b = 1'($urandom);
      else if (i <= 16) b = w[16-i];
      else              b = fill[15-((i-17)%16)];
      AUD_BCLK    = 1'b0;
      AUD_ADCLRCK = lr;
      AUD_ADCDAT  = b;
      repeat (8) @(posedge Clk);
      #1 AUD_BCLK = 1'b1;
      repeat (8) @(posedge Clk);
      #1;
    end
  endtask

  task automatic do_reset(input int n);
    Reset = 1'b1;
    repeat (n) @(posedge Clk);
    #1 Reset = 1'b0;
    exp_q.delete();
    m_prev_lr = 1'b0;
    m_track   = 1'b0;
    m_short   = 1'b0;
    m_left_ok = 1'b0;
  endtask

  task automatic frame(input logic [15:0] l, input logic [15:0] r,
                       input int n);
    send_chan(1'b0, l, n, 16'($urandom));
    send_chan(1'b1, r, n, 16'($urandom));
  endtask

  int v0, e0, p0;

  initial begin
    AUD_BCLK    = 1'b0;
    AUD_ADCLRCK = 1'b1;
    AUD_ADCDAT  = 1'b0;
    @(posedge Clk);
    #1 do_reset(4);
    @(negedge Clk);
    chk("reset_ldata", 32'(LDATA), 32'h0);
    chk("reset_rdata", 32'(RDATA), 32'h0);
    chk("reset_valid", 32'(sample_valid), 32'h0);
    chk("reset_error", 32'(frame_error), 32'h0);
    @(posedge Clk);
    #1;

    // Basic frame after an idle right channel
    v0 = n_valid;
    send_chan(1'b1, 16'($urandom), 17, 16'h0);
    frame(16'hA5C3, 16'h1234, 17);
    chk("t1_count", 32'(n_valid - v0), 32'd1);
    chk("t1_ldata", 32'(LDATA), 32'h0000A5C3);
    chk("t1_rdata", 32'(RDATA), 32'h00001234);

    // Reset released mid right channel
    v0 = n_valid;
    send_chan(1'b0, 16'($urandom), 17, 16'h0);
    send_chan(1'b1, 16'($urandom), 8, 16'h0);
    do_reset(1);
    send_chan(1'b1, 16'($urandom), 9, 16'h0);
    chk("t2_no_partial", 32'(n_valid - v0), 32'd0);
    frame(16'h0001, 16'h8000, 17);
    chk("t2_count", 32'(n_valid - v0), 32'd1);
    chk("t2_ldata", 32'(LDATA), 32'h00000001);
    chk("t2_rdata", 32'(RDATA), 32'h00008000);

    // Long channels with trailing ones
    e0 = n_err;
    send_chan(1'b0, 16'hBEEF, 32, 16'hFFFF);
    send_chan(1'b1, 16'hBEEF, 32, 16'hFFFF);
    send_chan(1'b0, 16'hBEEF, 32, 16'hFFFF);
    send_chan(1'b1, 16'hBEEF, 32, 16'hFFFF);
    chk("t3_ldata", 32'(LDATA), 32'h0000BEEF);
    chk("t3_rdata", 32'(RDATA), 32'h0000BEEF);
    chk("t3_no_error", 32'(n_err - e0), 32'd0);

    // Short left channel
    v0 = n_valid;
    e0 = n_err;
    send_chan(1'b0, 16'h5555, 10, 16'h0);
    send_chan(1'b1, 16'h6666, 17, 16'h0);
    chk("t4_error", 32'(n_err - e0), 32'd1);
    chk("t4_no_valid", 32'(n_valid - v0), 32'd0);
    chk("t4_ldata_kept", 32'(LDATA), 32'h0000BEEF);
    chk("t4_rdata_kept", 32'(RDATA), 32'h0000BEEF);
    frame(16'h1357, 16'h2468, 17);
    chk("t4_recover_ldata", 32'(LDATA), 32'h00001357);
    chk("t4_recover_rdata", 32'(RDATA), 32'h00002468);

    // One-cycle reset mid left channel
    v0 = n_valid;
    send_chan(1'b0, 16'($urandom), 8, 16'h0);
    do_reset(1);
    @(negedge Clk);
    chk("t5_ldata_zero", 32'(LDATA), 32'h0);
    chk("t5_rdata_zero", 32'(RDATA), 32'h0);
    @(posedge Clk);
    #1;
    send_chan(1'b0, 16'($urandom), 9, 16'h0);
    send_chan(1'b1, 16'($urandom), 17, 16'h0);
    frame(16'h7FFF, 16'h8001, 17);
    chk("t5_count", 32'(n_valid - v0), 32'd1);
    chk("t5_ldata", 32'(LDATA), 32'h00007FFF);
    chk("t5_rdata", 32'(RDATA), 32'h00008001);

    // 100 back-to-back random frames
    v0 = n_valid;
    p0 = pulse_cyc.size();
    for (int k = 0; k < 100; k++)
      frame(16'($urandom), 16'($urandom), 17);
    chk("t6_count", 32'(n_valid - v0), 32'd100);
    for (int k = p0 + 1; k < pulse_cyc.size(); k++)
      chk("t6_spacing", 32'(pulse_cyc[k] - pulse_cyc[k-1]),
          32'd544);

    repeat (20) @(posedge Clk);
    #1;
    chk("pending_expected", 32'(exp_q.size()), 32'd0);
    chk("total_valid", 32'(n_valid), 32'(exp_valid));
    chk("total_errors", 32'(n_err), 32'(exp_err));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
